// File: rtl/fp32_accumulator.sv
// fp32_accumulator: multi-cycle fp32 vector summer (align/add/normalize, truncating) with sticky exception.
// Define FACC_BIAS_EN to add a bias port that preloads the accumulator after reset and after each result.
module fp32_accumulator #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_exc,
    input  logic               in_last,
`ifdef FACC_BIAS_EN
    input  logic [31:0]        bias,
`endif
    output logic               out_valid,
    output logic [31:0]        out_sum,
    output logic               out_exc,
    output logic [COUNT_W-1:0] out_count
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t             r_state;
    logic [31:0]        r_acc, r_data;
    logic               r_exc, r_last, r_sticky, r_load, r_sign, r_sub, r_nan;
    logic [COUNT_W-1:0] r_count;
    logic [7:0]         r_exp;
    logic [23:0]        r_man_l, r_man_s;
    logic [24:0]        r_sum;
    logic [31:0]        w_init, w_a, w_b, w_big, w_small, w_res;
    logic [7:0]         w_diff;
    logic [23:0]        w_man_small;
    logic [22:0]        w_man_n;
    logic [4:0]         w_lz;
    logic [9:0]         w_exp_n;
    logic               w_nan, w_ovf;
`ifdef FACC_BIAS_EN
    assign w_init = bias;
`else
    assign w_init = 32'h0;
`endif
    assign in_ready = (r_state == IDLE) && !reset;
    // zero/denormal operands collapse to +0.0 before the magnitude ordering
    always_comb begin
        w_a = (r_acc[30:23] == 8'd0) ? 32'h0 : r_acc;
        w_b = (r_data[30:23] == 8'd0) ? 32'h0 : r_data;
        w_big = (w_a[30:0] >= w_b[30:0]) ? w_a : w_b;
        w_small = (w_a[30:0] >= w_b[30:0]) ? w_b : w_a;
        w_diff = w_big[30:23] - w_small[30:23];
        w_man_small = (w_diff >= 8'd26) ? 24'd0 : {|w_small[30:23], w_small[22:0]} >> w_diff;
        w_nan = r_exc || (&r_acc[30:23]) || (&r_data[30:23]);
    end
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++) if (r_sum[i]) w_lz = 5'(23 - i);
        w_man_n = r_sum[22:0] << w_lz;
        w_exp_n = r_sum[24] ? {2'b0, r_exp} + 10'd1 : {2'b0, r_exp} - {5'd0, w_lz};
        w_ovf = r_sum[24] && (r_exp == 8'd254);
        w_res = r_nan ? 32'h7FC00000 :
                w_ovf ? {r_sign, 8'hFF, 23'd0} :
                (r_sum == 25'd0 || w_exp_n[9] || w_exp_n == 10'd0) ? 32'h0 :
                r_sum[24] ? {r_sign, w_exp_n[7:0], r_sum[23:1]} :
                {r_sign, w_exp_n[7:0], w_man_n};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= 32'h0;
            r_data    <= 32'h0;
            r_exc     <= 1'b0;
            r_last    <= 1'b0;
            r_sticky  <= 1'b0;
            r_load    <= 1'b1;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_sub     <= 1'b0;
            r_nan     <= 1'b0;
            r_exp     <= 8'd0;
            r_man_l   <= 24'd0;
            r_man_s   <= 24'd0;
            r_sum     <= 25'd0;
            out_valid <= 1'b0;
            out_sum   <= 32'h0;
            out_exc   <= 1'b0;
            out_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_load) r_acc <= w_init;
                    r_load <= 1'b0;
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_exc   <= in_exc;
                        r_last  <= in_last;
                        r_count <= r_count + 1'b1;
                        r_state <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_sign  <= w_big[31];
                    r_sub   <= w_big[31] ^ w_small[31];
                    r_exp   <= w_big[30:23];
                    r_man_l <= {|w_big[30:23], w_big[22:0]};
                    r_man_s <= w_man_small;
                    r_nan   <= w_nan;
                    r_state <= ADD;
                end
                ADD: begin
                    r_sum   <= r_sub ? {1'b0, r_man_l} - {1'b0, r_man_s} : {1'b0, r_man_l} + {1'b0, r_man_s};
                    r_state <= NORM;
                end
                NORM: begin
                    r_acc    <= w_res;
                    r_sticky <= r_sticky || r_nan || w_ovf;
                    if (r_last) begin
                        out_valid <= 1'b1;
                        out_sum   <= w_res;
                        out_exc   <= r_sticky || r_nan || w_ovf;
                        out_count <= r_count;
                    end
                    r_state <= r_last ? DONE : IDLE;
                end
                DONE: begin
                    out_valid <= 1'b0;
                    r_acc     <= w_init;
                    r_sticky  <= 1'b0;
                    r_count   <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_accumulator.sv
// tb_fp32_accumulator: directed and random vectors checked against an arithmetic fp32 truncating-sum model.
module tb_fp32_accumulator;
    localparam int CW = 16;
    logic clk = 0, reset = 1, in_valid = 0, in_exc = 0, in_last = 0;
    logic [31:0] in_data = 0;
`ifdef FACC_BIAS_EN
    logic [31:0] bias = 0;
`endif
    logic in_ready, out_valid, out_exc;
    logic [31:0] out_sum;
    logic [CW-1:0] out_count;
    int checks = 0, errors = 0, cyc = 0, t_acc = 0, t_first = 0;
    logic [31:0] vd [8];
    logic ve [8];

    fp32_accumulator #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_exc(in_exc), .in_last(in_last),
`ifdef FACC_BIAS_EN
        .bias(bias),
`endif
        .out_valid(out_valid), .out_sum(out_sum), .out_exc(out_exc), .out_count(out_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // value = mantissa * 2^(exp-150); smaller operand truncated when aligned, result truncated
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, output logic ovf);
        longint ma, mb, ml, ms, s;
        int ea, eb, el, es, p, e;
        logic sa, sb, sl, ss;
        ovf = 0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : longint'({1'b1, a[22:0]});
        mb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]});
        sa = (ea == 0) ? 1'b0 : a[31];
        sb = (eb == 0) ? 1'b0 : b[31];
        if (ea > eb || (ea == eb && ma >= mb)) begin
            el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
        end else begin
            el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
        end
        s = (el - es >= 26) ? 0 : ms >> (el - es);
        s = (sl == ss) ? ml + s : ml - s;
        if (s == 0) return 32'h0;
        p = 0;
        while ((s >> (p + 1)) != 0) p++;
        e = el + p - 23;
        if (e >= 255) begin
            ovf = 1;
            return {sl, 8'hFF, 23'd0};
        end
        if (e <= 0) return 32'h0;
        s = (p >= 23) ? s >> (p - 23) : s << (23 - p);
        return {sl, e[7:0], s[22:0]};
    endfunction

    task automatic send(input logic [31:0] d, input logic e, input logic l);
        int k = 0;
        in_data = d; in_exc = e; in_last = l; in_valid = 1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", k < 50, 1);
        t_acc = cyc;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] es, input logic ee, input int ec, input int lat);
        int k = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, k < 60, 1);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_exc"}, out_exc, ee);
        check({tag, "_count"}, out_count, ec);
        if (lat > 0) check({tag, "_latency"}, cyc - t_first, lat);
        @(negedge clk);
        check({tag, "_pulse"}, out_valid, 0);
        check({tag, "_hold"}, out_sum, es);
    endtask

    task automatic run_vec(input string tag, input int n);
        logic [31:0] acc;
        logic st, ov;
        acc = 32'h0;
        st = 0;
        for (int i = 0; i < n; i++) begin
            if (ve[i] || (&acc[30:23]) || (&vd[i][30:23])) begin
                acc = 32'h7FC00000;
                st = 1;
            end else begin
                acc = fadd(acc, vd[i], ov);
                st = st | ov;
            end
        end
        for (int i = 0; i < n; i++) begin
            send(vd[i], ve[i], i == n - 1);
            if (i == 0) t_first = t_acc;
        end
        wait_result(tag, acc, st, n, 4 * n);
    endtask

    function automatic logic [31:0] rnd_fp();
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 39);
        e = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(115, 135));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    initial begin
        int rdy, n;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_exc", out_exc, 0);
        check("rst_count", out_count, 0);
        reset = 0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        vd[0] = 32'h3F800000; vd[1] = 32'h40000000; ve[0] = 0; ve[1] = 0;
        run_vec("one_plus_two", 2);
        vd[0] = 32'h40A00000; vd[1] = 32'hC0A00000;
        run_vec("cancel", 2);
        vd[0] = 32'h7F000000; vd[1] = 32'h7F000000;
        run_vec("overflow", 2);
        vd[0] = 32'h3F800000; vd[1] = 32'h33800000;
        run_vec("truncate", 2);
        vd[0] = 32'h3F800000; vd[1] = 32'h40000000; ve[0] = 1;
        run_vec("in_exc", 2);
        ve[0] = 0;
        check("cancel_model", fadd(32'h40A00000, 32'hC0A00000, in_exc), 32'h0);

        send(32'h3F800000, 0, 0);
        send(32'h3F800000, 0, 0);
        reset = 1;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 0);
        reset = 0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        vd[0] = 32'h40000000;
        run_vec("after_reset", 1);

        in_data = 32'h3F800000; in_exc = 0; in_last = 0; in_valid = 1;
        rdy = 0;
        for (int k = 0; k < 16; k++) begin
            rdy += int'(in_ready);
            @(negedge clk);
        end
        in_valid = 0;
        check("hold_ready_cycles", rdy, 4);
        send(32'h3F800000, 0, 1);
        wait_result("held_valid", 32'h40A00000, 0, 5, 0);

        for (int v = 0; v < 24; v++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                vd[i] = rnd_fp();
                ve[i] = ($urandom_range(0, 15) == 0);
            end
            run_vec("random", n);
        end

`ifdef FACC_BIAS_EN
        bias = 32'h3F800000;
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        send(32'h3F800000, 0, 1);
        t_first = t_acc;
        wait_result("bias", 32'h40000000, 0, 1, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_accumulator.md
# fp32_accumulator

Downstream consumer of the pipelined fp32 multiplier in the neuron datapath. Accepts a stream of IEEE-754 single-precision products (with the multiplier's exception flag) over a valid/ready handshake, sums one vector with a multi-cycle align/add/normalize state machine, and emits the dot-product sum plus a sticky exception flag when the element marked `last` has been added.

## Interface
- `COUNT_W`, default 16: width of the element counter and `out_count`.

- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  product on `in_data` is valid
- `in_ready`  output  1  block can accept a product this cycle
- `in_data`  input  32  fp32 product
- `in_exc`  input  1  multiplier exception for this product
- `in_last`  input  1  final element of the current vector
- `bias`  input  32  initial accumulator value; present only with `FACC_BIAS_EN`
- `out_valid`  output  1  one-cycle pulse, result valid
- `out_sum`  output  32  fp32 vector sum, held until next result
- `out_exc`  output  1  sticky exception for the vector, held with `out_sum`
- `out_count`  output  COUNT_W  elements accepted in the vector, held with `out_sum`

## Operation
- Reset values: `in_ready`=0 during reset, 1 in the first cycle after; `out_valid`=0, `out_sum`=0x00000000, `out_exc`=0, `out_count`=0; state IDLE; accumulator +0.0; sticky flag 0; counter 0.
- States: IDLE -> ALIGN -> ADD -> NORM -> (IDLE | DONE) -> IDLE.
  - IDLE: `in_ready`=1; on `in_valid` capture `in_data`, `in_exc`, `in_last`; counter += 1 (wraps at 2^COUNT_W).
  - ALIGN: order operands by magnitude; right-shift the smaller mantissa (hidden bit restored) by the exponent difference; difference >= 26 gives zero.
  - ADD: add or subtract 25-bit mantissas per signs; result sign is the larger operand's sign.
  - NORM: leading-zero count and shift in a single cycle; exponent adjusted; result truncated (round toward zero); written to the accumulator. If captured `last`, go to DONE, else IDLE.
  - DONE: `out_valid`=1; `out_sum`/`out_exc`/`out_count` loaded; accumulator, sticky flag and counter cleared.
- Special values:
  - Operand exponent 0 (zero/denormal) is treated as +0.0; denormal results flush to +0.0.
  - Exact cancellation gives +0.0 (0x00000000).
  - Exponent overflow gives signed infinity (0x7F800000 / 0xFF800000) and sets sticky.
  - An operand with exponent 255, or `in_exc`=1, sets sticky and forces the accumulator to 0x7FC00000 for the rest of the vector.
- `in_last` on an element sets the vector boundary. Elements accepted after DONE start a new vector.

## Timing
- Handshake: transfer only when `in_valid` && `in_ready`. Upstream holds data while `in_ready`=0. `in_ready` is 0 in ALIGN/ADD/NORM/DONE.
- Acceptance at cycle t: ALIGN t+1, ADD t+2, NORM t+3, accumulator updated at the end of t+3. `in_ready`=1 again at t+4 for a non-last element, giving one element per 4 cycles.
- Last element accepted at t: `out_valid`=1 at t+4, `in_ready`=1 at t+5.
- `in_valid` while busy is ignored. Reset asserted mid-vector immediately returns to IDLE and discards the partial sum with no `out_valid`.

## Configuration
- `FACC_BIAS_EN` defined: the `bias` port exists. The accumulator is loaded from `bias` after reset and at DONE, sampled at that cycle. A bias with exponent 255 sets sticky.
- `FACC_BIAS_EN` undefined: no `bias` port. The accumulator initialises to +0.0.

## Test plan
- Inputs 0x3F800000 (1.0), then 0x40000000 (2.0, last) -> `out_sum`=0x40400000, `out_exc`=0, `out_count`=2, `out_valid` 8 cycles after the first acceptance.
- Inputs 0x40A00000 then 0xC0A00000 (last) -> `out_sum`=0x00000000, `out_exc`=0.
- Inputs 0x7F000000 then 0x7F000000 (last) -> `out_sum`=0x7F800000, `out_exc`=1.
- Inputs 0x3F800000 then 0x33800000 (2^-24, last) -> `out_sum`=0x3F800000 (truncation); `in_exc`=1 on any element -> 0x7FC00000, `out_exc`=1.
- Two elements accepted, then `reset` pulsed, then 0x40000000 (last) -> `out_sum`=0x40000000, `out_count`=1; `in_valid` held continuously shows `in_ready` low 3 of every 4 cycles.
- With `FACC_BIAS_EN`, `bias`=0x3F800000 and a single input 0x3F800000 (last) -> `out_sum`=0x40000000.
